wb_stage: RTL
=============

# wb_stage

Writeback stage of the five-stage CPU and the write-side counterpart of the register file. It latches the MEM-stage result each cycle and formats load data by byte/halfword lane with sign or zero extension. It then drives the register-file write port (we/waddr/wdata) and the WB forwarding bus that the register file consumes for same-cycle bypass. A hold input and a flush input, plus a one-shot write qualifier, keep a held entry from being written twice.

## Interface
Parameters:
- `WB_TO_ID_WD`, 38: forwarding bus width, packed {wreg, waddr[4:0], wdata[31:0]}.

Ports:
- `clk` in 1: clock, rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `stall` in 1: hold the WB register contents.
- `flush` in 1: invalidate the WB register at the next edge.
- `mem_valid` in 1: MEM stage holds a valid instruction.
- `mem_pc` in 32: PC of the MEM instruction.
- `mem_wreg` in 1: instruction writes a GPR.
- `mem_waddr` in 5: destination GPR.
- `mem_wdata` in 32: ALU result, or the raw load word when a load.
- `mem_load_op` in 3: 000 none, 001 lb, 010 lbu, 011 lh, 100 lhu, 101 lw; 110/111 are treated as none.
- `mem_addr_lo` in 2: load address bits [1:0].
- `rf_we` out 1: register-file write enable.
- `rf_waddr` out 5: register-file write address.
- `rf_wdata` out 32: register-file write data.
- `wb_to_id_bus` out `WB_TO_ID_WD`: forwarding bus to the register file.
- `debug_wb_pc` out 32: trace PC (macro only).
- `debug_wb_rf_wen` out 4: trace write enable (macro only).
- `debug_wb_rf_wnum` out 5: trace register number (macro only).
- `debug_wb_rf_wdata` out 32: trace write data (macro only).

## Operation
WB register contents: valid, fresh, pc, wreg, waddr, data, load_op, addr_lo.

Register update on each rising edge, in priority order:
1. `flush`: valid←0, fresh←0.
2. `!stall`: capture all `mem_*` fields; valid←`mem_valid`; fresh←`mem_valid`.
3. `stall`: all fields hold; fresh←0.

Two-state view per entry: EMPTY (valid=0) and RESIDENT. In RESIDENT, fresh=1 only on the first cycle after capture.

Writeback qualification:
- wr_ok = valid & wreg & (waddr≠0).
- `rf_we` = wr_ok & fresh.
- `rf_waddr` = waddr.

Formatted data fmt, combinational from the registered fields:
- lb/lbu: select byte addr_lo (0 = bits[7:0] … 3 = bits[31:24]); lb sign-extends bit 7 of the selected byte, lbu zero-extends.
- lh/lhu: addr_lo[1] selects the halfword (0 = [15:0], 1 = [31:16]); addr_lo[0] is ignored. lh sign-extends, lhu zero-extends.
- lw / none: data unchanged.
- `rf_wdata` = fmt.

Forwarding bus:
- `wb_to_id_bus` = {wr_ok, waddr, fmt}.
- It stays asserted for the whole time an entry is held, even after `rf_we` has dropped.
- Never asserted for GPR 0.

## Timing
- Reset, asynchronous: valid, fresh, pc, wreg, waddr, data, load_op and addr_lo all become 0. Therefore `rf_we`=0, `rf_waddr`=0, `rf_wdata`=0, `wb_to_id_bus`=0, and all debug outputs are 0.
- Latency: MEM fields are captured at edge N. `rf_we` and the forwarding bus are valid during cycle N→N+1. The register array updates at edge N+1.
- Forwarding bus and `rf_*` are combinational from WB registers only; no path from `mem_*`.
- `stall` held k cycles: exactly one `rf_we` pulse, in the first cycle after capture; forwarding bus valid for all k+1 cycles.
- `flush` and `stall` asserted together: flush wins.
- Reset mid-hold: the entry is discarded and no write is issued after reset release.
- Back-to-back entries to the same GPR: one `rf_we` pulse each, in consecutive cycles.

## Configuration
- `WB_DEBUG_TRACE_EN` defined:
  - the four `debug_wb_*` ports exist and pc is registered.
  - `debug_wb_rf_wen` = {4{`rf_we`}}.
  - `debug_wb_rf_wnum` = waddr, `debug_wb_rf_wdata` = fmt, `debug_wb_pc` = pc.
  - Driven every cycle; the golden trace compares them only when wen≠0.
- Undefined: the debug ports and the pc register are absent; all other behaviour is identical.

## Test plan
- Reset, then release with `mem_valid`=0 → `rf_we`=0 and `wb_to_id_bus`=0 for 10 cycles.
- ALU op: waddr=5, wdata=0x1234_5678, load_op=000 → one cycle later `rf_we`=1, `rf_wdata`=0x1234_5678, bus=(1,5,0x1234_5678).
- Load extension on word 0x80FF_7F01:
  - lb, addr_lo=3 → 0xFFFF_FF80.
  - lbu, addr_lo=1 → 0x0000_007F.
  - lh, addr_lo=2 → 0xFFFF_80FF.
  - lhu, addr_lo=0 → 0x0000_7F01.
- Write to GPR 0 with wreg=1 → `rf_we`=0 and bus wreg=0.
- Stall for 3 cycles after capturing waddr=9 → a single `rf_we` pulse; bus=(1,9,data) for 4 cycles; debug wen pulses once.
- Flush and stall asserted together, then the entry released → valid cleared; no write and no bus assertion.

Source files
------------

// File: rtl/wb_stage.sv
// ============================================================================
// Module      : wb_stage
// Description : Writeback stage of the five-stage CPU. It latches the MEM
//               result, formats load data by byte/halfword lane with sign or
//               zero extension, and drives the register-file write port and
//               the WB forwarding bus. A one-shot "fresh" qualifier makes
//               sure a held entry is written to the register file only once.
//               Optional macro WB_DEBUG_TRACE_EN adds the debug_wb_* trace
//               ports and the pc register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_stage #(
    parameter int WB_TO_ID_WD = 38
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   stall,
    input  logic                   flush,
    input  logic                   mem_valid,
    input  logic [31:0]            mem_pc,
    input  logic                   mem_wreg,
    input  logic [4:0]             mem_waddr,
    input  logic [31:0]            mem_wdata,
    input  logic [2:0]             mem_load_op,
    input  logic [1:0]             mem_addr_lo,
    output logic                   rf_we,
    output logic [4:0]             rf_waddr,
    output logic [31:0]            rf_wdata,
    output logic [WB_TO_ID_WD-1:0] wb_to_id_bus
`ifdef WB_DEBUG_TRACE_EN
    ,
    output logic [31:0]            debug_wb_pc,
    output logic [3:0]             debug_wb_rf_wen,
    output logic [4:0]             debug_wb_rf_wnum,
    output logic [31:0]            debug_wb_rf_wdata
`endif
);

    localparam logic [2:0] C_OP_LB  = 3'b001;
    localparam logic [2:0] C_OP_LBU = 3'b010;
    localparam logic [2:0] C_OP_LH  = 3'b011;
    localparam logic [2:0] C_OP_LHU = 3'b100;

    logic        r_valid;
    logic        r_fresh;
    logic        r_wreg;
    logic [4:0]  r_waddr;
    logic [31:0] r_data;
    logic [2:0]  r_load_op;
    logic [1:0]  r_addr_lo;

    logic        w_wr_ok;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_fmt;

    // WB register: flush beats stall; a stalled entry loses its fresh flag
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_valid   <= 1'b0;
            r_fresh   <= 1'b0;
            r_wreg    <= 1'b0;
            r_waddr   <= 5'd0;
            r_data    <= 32'd0;
            r_load_op <= 3'd0;
            r_addr_lo <= 2'd0;
        end else if (flush) begin
            r_valid <= 1'b0;
            r_fresh <= 1'b0;
        end else if (!stall) begin
            r_valid   <= mem_valid;
            r_fresh   <= mem_valid;
            r_wreg    <= mem_wreg;
            r_waddr   <= mem_waddr;
            r_data    <= mem_wdata;
            r_load_op <= mem_load_op;
            r_addr_lo <= mem_addr_lo;
        end else begin
            r_fresh <= 1'b0;
        end
    end

`ifdef WB_DEBUG_TRACE_EN
    logic [31:0] r_pc;

    // Trace PC follows the same capture/hold rules as the rest of the entry
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_pc <= 32'd0;
        end else if (!flush && !stall) begin
            r_pc <= mem_pc;
        end
    end

    assign debug_wb_pc       = r_pc;
    assign debug_wb_rf_wen   = {4{rf_we}};
    assign debug_wb_rf_wnum  = r_waddr;
    assign debug_wb_rf_wdata = w_fmt;
`else
    // The PC is only needed for tracing; fold it into a sink signal
    logic w_unused_pc;
    assign w_unused_pc = ^mem_pc;
`endif

    // Load formatting: pick the addressed lane, then sign/zero extend
    always_comb begin
        w_byte = 8'd0;
        w_half = 16'd0;
        w_fmt  = r_data;
        case (r_addr_lo)
            2'd0:    w_byte = r_data[7:0];
            2'd1:    w_byte = r_data[15:8];
            2'd2:    w_byte = r_data[23:16];
            default: w_byte = r_data[31:24];
        endcase
        w_half = r_addr_lo[1] ? r_data[31:16] : r_data[15:0];
        case (r_load_op)
            C_OP_LB:  w_fmt = {{24{w_byte[7]}}, w_byte};
            C_OP_LBU: w_fmt = {24'd0, w_byte};
            C_OP_LH:  w_fmt = {{16{w_half[15]}}, w_half};
            C_OP_LHU: w_fmt = {16'd0, w_half};
            default:  w_fmt = r_data;
        endcase
    end

    // GPR 0 is never written nor forwarded
    assign w_wr_ok      = r_valid & r_wreg & (r_waddr != 5'd0);
    assign rf_we        = w_wr_ok & r_fresh;
    assign rf_waddr     = r_waddr;
    assign rf_wdata     = w_fmt;
    assign wb_to_id_bus = {w_wr_ok, r_waddr, w_fmt};

endmodule

`default_nettype wire
